// File: rtl/alu_writeback_pkg.sv
// ---------------------------------------------------------------------------
// alu_writeback_pkg
//   Shared definitions for the ALU write-back stage: opcode encodings of the
//   cpu_2432 instruction set that this stage cares about, the default
//   multi-cycle penalty, the flag-register layout and a small helper for
//   MOVT upper-half placement.
// ---------------------------------------------------------------------------
package alu_writeback_pkg;

  // Opcode encodings (6-bit ex_opcode field).
  localparam logic [5:0] OP_ADD   = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_AND   = 6'h03;
  localparam logic [5:0] OP_CMP   = 6'h08;
  localparam logic [5:0] OP_BTST  = 6'h0A;
  localparam logic [5:0] OP_MUL   = 6'h10;
  localparam logic [5:0] OP_LMOVT = 6'h14;
  localparam logic [5:0] OP_DJNZ  = 6'h1C;

  // Extra execute cycles granted to an operation flagged alu_mcp.
  localparam int MCP_CYCLES_DEFAULT = 1;

  // Architectural flags, packed so that the vector reads {S,Z,V,C}.
  typedef struct packed {
    logic s;
    logic z;
    logic v;
    logic c;
  } flags_t;

  // MOVT writes the low half of the ALU result into the upper register half.
  function automatic logic [31:0] movt_place(input logic [31:0] d);
    return {d[15:0], 16'h0000};
  endfunction

endpackage

// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//   Pipeline stage directly after the ALU. Registers the ALU result onto the
//   register-file write port, sequences multi-cycle ALU operations, owns the
//   architectural flag register and reports DJNZ loop-taken to fetch.
//
// Ports
//   clk, reset_b          clock, asynchronous active-low reset
//   ex_valid              execute stage presents an instruction
//   ex_opcode             instruction opcode
//   ex_rdest              destination register
//   ex_setflags, ex_wren  instruction updates flags / writes the register file
//   alu_dout/cout/vout    ALU result, carry and overflow
//   alu_qnzout            DJNZ counter result is non-zero
//   alu_mcp               ALU result needs MCP_CYCLES extra cycles
//   ex_stall              hold execute (operands and ALU inputs stay stable)
//   wb_valid/ready        register-file write request / accept
//   wb_addr/data/be       write address, data, half-word enables {hi,lo}
//   flags                 {S,Z,V,C}, also feeds ALU cin/vin
//   djnz_taken            registered one-cycle loop-taken pulse
// ---------------------------------------------------------------------------
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int REGADDR_W  = 4,
  parameter int MCP_CYCLES = MCP_CYCLES_DEFAULT  // legal range 1..7
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 ex_valid,
  input  logic [5:0]           ex_opcode,
  input  logic [REGADDR_W-1:0] ex_rdest,
  input  logic                 ex_setflags,
  input  logic                 ex_wren,
  input  logic [31:0]          alu_dout,
  input  logic                 alu_cout,
  input  logic                 alu_vout,
  input  logic                 alu_qnzout,
  input  logic                 alu_mcp,
  output logic                 ex_stall,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [REGADDR_W-1:0] wb_addr,
  output logic [31:0]          wb_data,
  output logic [1:0]           wb_be,
  output logic [3:0]           flags,
  output logic                 djnz_taken
);

  typedef enum logic {
    RUN = 1'b0,
    MCP = 1'b1
  } state_t;

  // Counter load value: the first extra cycle is spent on the RUN->MCP edge.
  localparam logic [2:0] CNT_INIT = 3'(MCP_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [REGADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [31:0]            wb_data_q, wb_data_d;
  logic [1:0]             wb_be_q, wb_be_d;
  flags_t                 flags_q, flags_d;
  logic                   djnz_q, djnz_d;

  logic slot_free;
  logic accept;
  logic capture;

  // The write slot is free when nothing is pending or the pending write
  // completes on this edge.
  assign slot_free = ~wb_valid_q | wb_ready;
  assign accept    = ex_valid & slot_free;

  assign ex_stall = (ex_valid & ~slot_free)
                  | ((state_q == RUN) & accept & alu_mcp)
                  | ((state_q == MCP) & (cnt_q != 3'd0));

  // Sequencer: decides on which edge the instruction is captured.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          if (alu_mcp) begin
            state_d = MCP;
            cnt_d   = CNT_INIT;
          end else begin
            capture = 1'b1;
          end
        end
      end
      MCP: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (accept) begin
          // Result ready and the write slot free: finish the operation.
          capture = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Write port, flags and DJNZ pulse.
  always_comb begin
    wb_valid_d = wb_valid_q & ~wb_ready;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_be_d    = wb_be_q;
    flags_d    = flags_q;
    djnz_d     = 1'b0;

    if (capture) begin
      // A capture only happens with the slot free, so any older write is
      // completing on this same edge and the new request simply replaces it.
      wb_valid_d = ex_wren;
      wb_addr_d  = ex_rdest;
      if (ex_opcode == OP_LMOVT) begin
        wb_data_d = movt_place(alu_dout);
        wb_be_d   = 2'b10;
      end else begin
        wb_data_d = alu_dout;
        wb_be_d   = 2'b11;
      end

      if (ex_setflags) begin
        if (ex_opcode == OP_BTST) begin
          flags_d.z = (alu_dout == 32'h0);
        end else begin
          flags_d.s = alu_dout[31];
          flags_d.z = (alu_dout == 32'h0);
          flags_d.v = alu_vout;
          flags_d.c = alu_cout;
        end
      end

      djnz_d = (ex_opcode == OP_DJNZ) & alu_qnzout;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= RUN;
      cnt_q      <= 3'd0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= 32'h0;
      wb_be_q    <= 2'b00;
      flags_q    <= '0;
      djnz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_be_q    <= wb_be_d;
      flags_q    <= flags_d;
      djnz_q     <= djnz_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign wb_be      = wb_be_q;
  assign flags      = flags_q;
  assign djnz_taken = djnz_q;

endmodule

// File: tb/tb_alu_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback
//   Self-checking bench for alu_writeback (MCP_CYCLES = 2). A behavioural
//   model tracks, per instruction, how many extra cycles it has been served
//   and what the write port and flags must hold; a directed table, a few
//   hand-written multi-cycle sequences and a random phase are all checked
//   against it.
// ---------------------------------------------------------------------------
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  localparam int AW  = 4;
  localparam int MCP = 2;

  logic          clk;
  logic          reset_b;
  logic          ex_valid;
  logic [5:0]    ex_opcode;
  logic [AW-1:0] ex_rdest;
  logic          ex_setflags;
  logic          ex_wren;
  logic [31:0]   alu_dout;
  logic          alu_cout;
  logic          alu_vout;
  logic          alu_qnzout;
  logic          alu_mcp;
  logic          ex_stall;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_data;
  logic [1:0]    wb_be;
  logic [3:0]    flags;
  logic          djnz_taken;

  alu_writeback #(.REGADDR_W(AW), .MCP_CYCLES(MCP)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .ex_rdest   (ex_rdest),
    .ex_setflags(ex_setflags),
    .ex_wren    (ex_wren),
    .alu_dout   (alu_dout),
    .alu_cout   (alu_cout),
    .alu_vout   (alu_vout),
    .alu_qnzout (alu_qnzout),
    .alu_mcp    (alu_mcp),
    .ex_stall   (ex_stall),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_be      (wb_be),
    .flags      (flags),
    .djnz_taken (djnz_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  logic [1:0]    m_be;
  logic [3:0]    m_flags;   // {S,Z,V,C}
  logic          m_djnz;
  int            m_served;  // extra cycles served to the current instruction

  logic [AW-1:0] hs_q[$];   // addresses of writes seen handed to the regfile

  task automatic model_reset();
    m_valid  = 1'b0;
    m_addr   = '0;
    m_data   = 32'h0;
    m_be     = 2'b00;
    m_flags  = 4'h0;
    m_djnz   = 1'b0;
    m_served = 0;
  endtask

  function automatic logic [43:0] dut_regs();
    return {wb_valid, wb_addr, wb_data, wb_be, flags, djnz_taken};
  endfunction

  function automatic logic [43:0] model_regs();
    return {m_valid, m_addr, m_data, m_be, m_flags, m_djnz};
  endfunction

  // One clock cycle with the currently driven inputs. Checks ex_stall and the
  // registered outputs at the falling edge, then advances the model across
  // the rising edge and returns 1 time unit after it.
  task automatic cycle(output logic stall_seen);
    logic slot_free, done, exp_stall;
    @(negedge clk);
    slot_free = !m_valid || wb_ready;
    // An instruction finishes once it has had all its extra cycles and its
    // result has somewhere to go.
    done      = ex_valid && slot_free && (!alu_mcp || m_served == MCP);
    exp_stall = ex_valid && !done;
    check("ex_stall", 64'(ex_stall), 64'(exp_stall));
    check("outputs", 64'(dut_regs()), 64'(model_regs()));
    stall_seen = ex_stall;
    if (wb_valid && wb_ready) hs_q.push_back(wb_addr);
    @(posedge clk);
    if (done) begin
      m_valid = ex_wren;
      m_addr  = ex_rdest;
      if (ex_opcode == OP_LMOVT) begin
        m_data = (alu_dout & 32'h0000_FFFF) << 16;
        m_be   = 2'b10;
      end else begin
        m_data = alu_dout;
        m_be   = 2'b11;
      end
      if (ex_setflags) begin
        if (ex_opcode == OP_BTST) m_flags[2] = (alu_dout == 0);
        else m_flags = {alu_dout[31], alu_dout == 0, alu_vout, alu_cout};
      end
      m_served = 0;
    end else begin
      if (m_valid && wb_ready) m_valid = 1'b0;
      // Extra cycles start once the slot was free and then run unconditionally.
      if (ex_valid && alu_mcp && m_served < MCP && (m_served > 0 || slot_free))
        m_served++;
    end
    m_djnz = done && ex_opcode == OP_DJNZ && alu_qnzout;
    #1;
  endtask

  task automatic drive(input logic vld, input logic [5:0] op, input logic [AW-1:0] rd,
                       input logic sf, input logic wr, input logic [31:0] d,
                       input logic c, input logic v, input logic q, input logic mcp);
    ex_valid    = vld;
    ex_opcode   = op;
    ex_rdest    = rd;
    ex_setflags = sf;
    ex_wren     = wr;
    alu_dout    = d;
    alu_cout    = c;
    alu_vout    = v;
    alu_qnzout  = q;
    alu_mcp     = mcp;
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic          vld;
    logic [5:0]    op;
    logic [AW-1:0] rd;
    logic          sf;
    logic          wr;
    logic [31:0]   dout;
    logic          c;
    logic          v;
    logic          q;
    logic          e_valid;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_data;
    logic [1:0]    e_be;
    logic [3:0]    e_flags;
    logic          e_djnz;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic          st;
    int            stalls;
    logic [5:0]    ops[8];

    ops = '{OP_ADD, OP_SUB, OP_AND, OP_CMP, OP_BTST, OP_MUL, OP_LMOVT, OP_DJNZ};

    // -------- reset --------
    model_reset();
    reset_b  = 1'b0;
    wb_ready = 1'b1;
    drive(1'b0, OP_ADD, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_outputs", 64'(dut_regs()), 64'h0);
    check("reset_stall", 64'(ex_stall), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_b = 1'b1;
    @(posedge clk);
    #1;

    // -------- table-driven single-cycle instructions --------
    //               vld op       rd  sf wr dout          c  v  q    valid addr data          be     flags   djnz
    vecs.push_back('{1'b1, OP_ADD,   4'd5,  1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5,  32'h0000_0000, 2'b11, 4'b0101, 1'b0});
    vecs.push_back('{1'b1, OP_LMOVT, 4'd3,  1'b0, 1'b1, 32'h1234_ABCD, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  32'hABCD_0000, 2'b10, 4'b0101, 1'b0});
    vecs.push_back('{1'b1, OP_ADD,   4'd15, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 32'hFFFF_FFFF, 2'b11, 4'b1010, 1'b0});
    vecs.push_back('{1'b1, OP_BTST,  4'd2,  1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  32'h0000_0000, 2'b11, 4'b1110, 1'b0});
    vecs.push_back('{1'b1, OP_CMP,   4'd0,  1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  32'h7FFF_FFFF, 2'b11, 4'b0011, 1'b0});
    vecs.push_back('{1'b1, OP_DJNZ,  4'd7,  1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7,  32'h0000_0004, 2'b11, 4'b0011, 1'b1});
    vecs.push_back('{1'b1, OP_DJNZ,  4'd7,  1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7,  32'h0000_0000, 2'b11, 4'b0011, 1'b0});
    vecs.push_back('{1'b0, OP_ADD,   4'd9,  1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7,  32'h0000_0000, 2'b11, 4'b0011, 1'b0});
    vecs.push_back('{1'b1, OP_BTST,  4'd1,  1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1,  32'h0000_0000, 2'b11, 4'b0111, 1'b0});
    vecs.push_back('{1'b1, OP_ADD,   4'd12, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 32'h0000_0001, 2'b11, 4'b0111, 1'b0});

    wb_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].vld, vecs[i].op, vecs[i].rd, vecs[i].sf, vecs[i].wr, vecs[i].dout,
            vecs[i].c, vecs[i].v, vecs[i].q, 1'b0);
      cycle(st);
      check($sformatf("vec%0d_stall", i), 64'(st), 64'h0);
      check($sformatf("vec%0d_out", i), 64'(dut_regs()),
            64'({vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_be,
                 vecs[i].e_flags, vecs[i].e_djnz}));
    end

    // -------- multi-cycle MUL: two stall cycles, capture on the third edge --------
    drive(1'b1, OP_MUL, 4'd4, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(st);
      if (!st) break;
      stalls++;
    end
    check("mul_stall_cycles", 64'(stalls), 64'd2);
    check("mul_result", 64'({wb_valid, wb_addr, wb_data, wb_be}),
          64'({1'b1, 4'd4, 32'h8000_0000, 2'b11}));
    check("mul_flags", 64'(flags), 64'b1000);

    // -------- back-pressure: pending write blocks a new one for 3 cycles --------
    drive(1'b0, OP_ADD, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(st);
    hs_q.delete();
    drive(1'b1, OP_ADD, 4'd10, 1'b0, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(st);
    drive(1'b1, OP_ADD, 4'd6, 1'b0, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0);
    wb_ready = 1'b0;
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(st);
      if (st) stalls++;
    end
    check("bp_stall_cycles", 64'(stalls), 64'd3);
    check("bp_pending_addr", 64'({wb_valid, wb_addr}), 64'({1'b1, 4'd10}));
    wb_ready = 1'b1;
    cycle(st);
    check("bp_release_stall", 64'(st), 64'h0);
    check("bp_new_write", 64'({wb_valid, wb_addr, wb_data}), 64'({1'b1, 4'd6, 32'h55}));
    drive(1'b0, OP_ADD, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(st);
    check("bp_write_count", 64'(hs_q.size()), 64'd2);
    if (hs_q.size() == 2) begin
      check("bp_write0_addr", 64'(hs_q[0]), 64'd10);
      check("bp_write1_addr", 64'(hs_q[1]), 64'd6);
    end

    // -------- reset while an MCP op is counting --------
    drive(1'b1, OP_MUL, 4'd12, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(st);
    check("mcp_pre_reset_stall", 64'(st), 64'h1);
    #2;
    reset_b  = 1'b0;
    ex_valid = 1'b0;
    #1;
    check("mcp_reset_outputs", 64'(dut_regs()), 64'h0);
    check("mcp_reset_stall", 64'(ex_stall), 64'h0);
    model_reset();
    @(negedge clk) reset_b = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, OP_ADD, 4'd9, 1'b1, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(st);
    check("post_reset_stall", 64'(st), 64'h0);
    check("post_reset_capture", 64'({wb_valid, wb_addr, wb_data, flags}),
          64'({1'b1, 4'd9, 32'h55, 4'b0000}));

    // -------- randomized traffic against the model --------
    st = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!st) begin
        logic [5:0] op;
        op = ops[$urandom_range(0, 7)];
        drive($urandom_range(0, 3) != 0, op, AW'($urandom), 1'($urandom),
              (op == OP_CMP) ? 1'b0 : 1'($urandom),
              ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
              1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3) == 0);
      end
      wb_ready = $urandom_range(0, 9) < 7;
      cycle(st);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Pipeline stage directly downstream of the ALU. Registers the ALU result and sequences multi-cycle ALU operations (mcp, e.g. 32x32 MUL).
- Owns the architectural flag register (C, V, Z, S) and produces the register-file write port, including MOVT upper-half placement.
- Reports DJNZ loop-taken to the fetch unit.
- Applies back-pressure to the execute stage via ex_stall.

Parameters:
- REGADDR_W, 4, register-file address width.
- MCP_CYCLES, 1, extra cycles granted when alu_mcp is set; legal range 1..7.

Ports:
- clk  in  1  system clock.
- reset_b  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage presents a valid instruction.
- ex_opcode  in  6  opcode, encodings from cpu_2432.vh.
- ex_rdest  in  REGADDR_W  destination register.
- ex_setflags  in  1  instruction updates flags.
- ex_wren  in  1  instruction writes the register file.
- alu_dout  in  32  ALU result.
- alu_cout  in  1  ALU carry out.
- alu_vout  in  1  ALU overflow out.
- alu_qnzout  in  1  DJNZ non-zero result.
- alu_mcp  in  1  ALU result needs extra cycles.
- ex_stall  out  1  hold execute stage; operands and ALU inputs stay stable.
- wb_valid  out  1  write-port request.
- wb_ready  in  1  register file accepts the write.
- wb_addr  out  REGADDR_W  write address.
- wb_data  out  32  write data.
- wb_be  out  2  half-word enables: [1] = bits 31:16, [0] = bits 15:0.
- flags  out  4  {S,Z,V,C}; also drives ALU cin/vin.
- djnz_taken  out  1  one-cycle pulse, registered.

Behaviour:
- Reset (asynchronous, reset_b low): state=RUN, cnt=0, wb_valid=0, wb_addr=0, wb_data=0, wb_be=0, flags=0, djnz_taken=0. ex_stall is combinational and therefore 0.
  - Reset asserted mid-MCP: the pending operation is discarded.
- accept = ex_valid & (~wb_valid | wb_ready).
- ex_stall = (ex_valid & ~(~wb_valid | wb_ready)) | (state==RUN & accept & alu_mcp) | (state==MCP & cnt!=0).
- State machine:
  - RUN, accept & ~alu_mcp: capture this edge.
  - RUN, accept & alu_mcp: go to MCP with cnt=MCP_CYCLES-1; no capture.
  - MCP, cnt!=0: cnt decrements each cycle.
  - MCP, cnt==0: capture if the write slot is free, then go to RUN. If the slot is not free, stay in MCP and assert ex_stall via the back-pressure term.
  - Execute occupancy for an mcp op with no back-pressure: MCP_CYCLES+1 cycles.
- Capture (single edge):
  - wb_valid = ex_wren.
  - wb_addr = ex_rdest.
  - For LMOVT: wb_data = {alu_dout[15:0],16'h0}, wb_be = 2'b10.
  - Otherwise: wb_data = alu_dout, wb_be = 2'b11.
- Write handshake:
  - wb_valid clears on wb_ready unless a new capture with ex_wren=1 occurs on the same edge.
  - On the same edge, the new capture wins and the old write completes.
- Flags update on the capture edge only, when ex_setflags=1:
  - C = alu_cout, V = alu_vout, Z = (alu_dout==0), S = alu_dout[31].
  - BTST updates Z only.
  - CMP updates flags; the decoder supplies ex_wren=0 for CMP.
- djnz_taken = 1 on the cycle after a DJNZ capture with alu_qnzout=1; else 0.
- Instructions with ex_valid=0 change nothing.
- Flags stay stable while the stage is stalled.

Decomposition:
- Opcode encodings come from the existing shared include cpu_2432.vh; add define MCP_CYCLES_DEFAULT there.
- State encodings RUN/MCP are local parameters.
- No sub-module is needed; the mcp counter is inline.

Test Plan:
- ADD with alu_dout=32'h0, cout=1, vout=0, setflags, wren, rdest=5, wb_ready=1 -> next cycle wb_valid=1, wb_addr=5, wb_be=2'b11, flags={S,Z,V,C}=0101, ex_stall never asserted.
- MUL with alu_mcp=1, MCP_CYCLES=2, result 32'h8000_0000 -> ex_stall high for 2 cycles; capture on 3rd edge; flags S=1; wb_data=32'h8000_0000.
- LMOVT with alu_dout=32'h1234_ABCD -> wb_data=32'hABCD_0000, wb_be=2'b10, flags unchanged.
- wb_ready=0 for 3 cycles with a pending write and a new ex_valid -> ex_stall high 3 cycles; new write captured on the edge wb_ready returns; no write lost or duplicated.
- DJNZ with alu_qnzout=1, then DJNZ with alu_qnzout=0 -> djnz_taken pulses exactly one cycle for the first only.
- reset_b low during MCP cnt=1 -> immediate RUN, wb_valid=0, flags=0; after release the next non-mcp op captures in one cycle.
